// File: rtl/m_issue_ctrl.sv
// ---------------------------------------------------------------------------
// m_issue_ctrl
//   EX-stage issue/sequencing stage in front of the combinational RV32M
//   multiplier. One multiply request is accepted at a time, its operands and
//   op code are registered and held on the multiplier inputs for MUL_LAT
//   cycles, then the multiplier result is captured and returned to writeback
//   over a valid/ready handshake. While the stage cannot take a new request,
//   stall is raised to freeze the upstream pipeline.
//
// Parameters
//   DATA_W   operand/result width
//   OP_W     ALU op-code width
//   MUL_LAT  cycles operands are held on the multiplier inputs (1..8)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake from ID/EX
//   req_op/rs1/rs2/rd        request payload
//   flush                    kills any in-flight or pending result
//   mul_in1/mul_in2/mul_op   registered operands/op code to the multiplier
//   mul_result               combinational multiplier result
//   rsp_valid/rsp_ready      response handshake to writeback
//   rsp_data/rsp_rd          captured result and its destination register
//   stall                    inverse of req_ready
//
// Optional feature (macro MUL_REUSE_EN)
//   When defined, the {op,rs1,rs2} tag and result of the last completed
//   multiply are kept. A new request with an identical tag skips EXEC and is
//   answered from the stored result on the next cycle. flush/rst invalidate
//   the stored tag. When undefined, every request goes through EXEC.
// ---------------------------------------------------------------------------
module m_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 6,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_rs1,
    input  logic [DATA_W-1:0] req_rs2,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic [DATA_W-1:0] mul_in1,
    output logic [DATA_W-1:0] mul_in2,
    output logic [OP_W-1:0]   mul_op,
    input  logic [DATA_W-1:0] mul_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              stall
);

    // Counter holds MUL_LAT-1 down to 0, so it never needs to wrap.
    localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] in1_reg, in2_reg, rsp_data_reg;
    logic [OP_W-1:0]   op_reg;
    logic [4:0]        rd_reg;

    logic              accept;
    logic              exec_last;
    logic              reuse_hit;
    logic [DATA_W-1:0] reuse_data;

    // A pending result may be replaced in the same cycle it is consumed,
    // which is what gives back-to-back issue out of DONE.
    assign req_ready = ((state_reg == IDLE) || ((state_reg == DONE) && rsp_ready)) && !flush;
    assign stall     = ~req_ready;
    assign accept    = req_valid && req_ready;
    assign exec_last = (state_reg == EXEC) && (cnt_reg == '0);

    assign rsp_valid = (state_reg == DONE);
    assign mul_in1   = in1_reg;
    assign mul_in2   = in2_reg;
    assign mul_op    = op_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_rd    = rd_reg;

`ifdef MUL_REUSE_EN
    logic              tag_valid_reg;
    logic [OP_W-1:0]   tag_op_reg;
    logic [DATA_W-1:0] tag_rs1_reg, tag_rs2_reg, tag_result_reg;

    assign reuse_hit  = tag_valid_reg && (tag_op_reg == req_op) &&
                        (tag_rs1_reg == req_rs1) && (tag_rs2_reg == req_rs2);
    assign reuse_data = tag_result_reg;

    // Tag is taken from the registered operands at the same edge that the
    // result is captured, so tag and result always describe one operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_reg  <= 1'b0;
            tag_op_reg     <= '0;
            tag_rs1_reg    <= '0;
            tag_rs2_reg    <= '0;
            tag_result_reg <= '0;
        end else if (flush) begin
            tag_valid_reg <= 1'b0;
        end else if (exec_last) begin
            tag_valid_reg  <= 1'b1;
            tag_op_reg     <= op_reg;
            tag_rs1_reg    <= in1_reg;
            tag_rs2_reg    <= in2_reg;
            tag_result_reg <= mul_result;
        end
    end
`else
    assign reuse_hit  = 1'b0;
    assign reuse_data = '0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = reuse_hit ? DONE : EXEC;
                    cnt_next   = CNT_LOAD;
                end
            end
            EXEC: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = reuse_hit ? DONE : EXEC;
                    cnt_next   = CNT_LOAD;
                end else if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Kill wins over everything, including a same-cycle handshake.
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            in1_reg      <= '0;
            in2_reg      <= '0;
            op_reg       <= '0;
            rd_reg       <= '0;
            rsp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                in1_reg <= req_rs1;
                in2_reg <= req_rs2;
                op_reg  <= req_op;
                rd_reg  <= req_rd;
            end
            // accept and exec_last are mutually exclusive (EXEC never accepts).
            if (exec_last && !flush) begin
                rsp_data_reg <= mul_result;
            end else if (accept && reuse_hit) begin
                rsp_data_reg <= reuse_data;
            end
        end
    end

endmodule

// File: tb/tb_m_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_m_issue_ctrl
//   Randomized bench for m_issue_ctrl. Three instances (MUL_LAT = 1, 2, 8)
//   share one stimulus stream; each has a stand-in RV32M multiplier and its
//   own transaction-level reference model that predicts, from the accept
//   cycle, when the result appears, what it is, and when requests can be
//   taken. Honors MUL_REUSE_EN if defined for the compile.
// ---------------------------------------------------------------------------
module tb_m_issue_ctrl;

    localparam int NI     = 3;
    localparam int NCYC   = 3000;
    localparam logic [5:0] OP_MUL    = 6'd1;
    localparam logic [5:0] OP_MULH   = 6'd2;
    localparam logic [5:0] OP_MULHSU = 6'd3;
    localparam logic [5:0] OP_MULHU  = 6'd4;
`ifdef MUL_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req_valid, flush, rsp_ready;
    logic [5:0]  req_op;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;

    logic        req_ready_w [NI];
    logic        stall_w     [NI];
    logic        rsp_valid_w [NI];
    logic [31:0] mul_in1_w   [NI];
    logic [31:0] mul_in2_w   [NI];
    logic [31:0] mul_res_w   [NI];
    logic [31:0] rsp_data_w  [NI];
    logic [5:0]  mul_op_w    [NI];
    logic [4:0]  rsp_rd_w    [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // RV32M semantics: low word for MUL, high word of the 64-bit product
    // with the operand signedness of each variant; anything else gives 0.
    function automatic logic [31:0] mul_ref(logic [5:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MUL:    begin p = ua * ub; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            default:   return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 8);
    endfunction

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            m_issue_ctrl #(
                .DATA_W (32),
                .OP_W   (6),
                .MUL_LAT((gi == 0) ? 1 : ((gi == 1) ? 2 : 8))
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .req_valid (req_valid),
                .req_ready (req_ready_w[gi]),
                .req_op    (req_op),
                .req_rs1   (req_rs1),
                .req_rs2   (req_rs2),
                .req_rd    (req_rd),
                .flush     (flush),
                .mul_in1   (mul_in1_w[gi]),
                .mul_in2   (mul_in2_w[gi]),
                .mul_op    (mul_op_w[gi]),
                .mul_result(mul_res_w[gi]),
                .rsp_valid (rsp_valid_w[gi]),
                .rsp_ready (rsp_ready),
                .rsp_data  (rsp_data_w[gi]),
                .rsp_rd    (rsp_rd_w[gi]),
                .stall     (stall_w[gi])
            );
            assign mul_res_w[gi] = mul_ref(mul_op_w[gi], mul_in1_w[gi], mul_in2_w[gi]);
        end
    endgenerate

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model, per instance: an operation is either absent or owns a
    // result that becomes visible at cycle m_done.
    bit          m_busy [NI];
    int          m_done [NI];
    int          m_acc  [NI];
    logic [31:0] m_data [NI];
    logic [31:0] m_in1  [NI];
    logic [31:0] m_in2  [NI];
    logic [5:0]  m_op   [NI];
    logic [4:0]  m_rd   [NI];
    logic [31:0] m_rspd [NI];
    bit          t_v    [NI];
    logic [5:0]  t_op   [NI];
    logic [31:0] t_a    [NI];
    logic [31:0] t_b    [NI];

    logic [31:0] pool_a [6];
    logic [31:0] pool_b [6];

    initial begin
        int t;
        bit exp_done, exp_rdy, hit;

        pool_a = '{32'd7, 32'hFFFF_FFFF, 32'h4000_0000, 32'h8000_0000, 32'd0, 32'd1};
        pool_b = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd4, 32'h7FFF_FFFF, 32'd2, 32'h8000_0000};

        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
        for (int k = 0; k < NI; k++) begin
            m_busy[k] = 1'b0; m_done[k] = 0; m_acc[k] = 0; m_data[k] = '0;
            m_in1[k] = '0; m_in2[k] = '0; m_op[k] = '0; m_rd[k] = '0; m_rspd[k] = '0;
            t_v[k] = 1'b0; t_op[k] = '0; t_a[k] = '0; t_b[k] = '0;
        end
        repeat (2) @(posedge clk);
        t = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Stimulus: rare reset, occasional flush, bursty backpressure,
            // repeated requests so identical tags recur.
            rst       = (cyc > 20) && ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 14) == 0);
            rsp_ready = ($urandom_range(0, 99) < 65);
            req_valid = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 2) == 0) begin
                req_op = 6'($urandom_range(0, 7));
                req_rd = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 1) == 0) begin
                    req_rs1 = pool_a[$urandom_range(0, 5)];
                    req_rs2 = pool_b[$urandom_range(0, 5)];
                end else begin
                    req_rs1 = $urandom;
                    req_rs2 = $urandom;
                end
            end
            #1;
            for (int k = 0; k < NI; k++) begin
                exp_done = m_busy[k] && (t >= m_done[k]);
                exp_rdy  = (!m_busy[k] || (exp_done && rsp_ready)) && !flush;
                check($sformatf("L%0d c%0d req_ready", lat_of(k), t), 32'(req_ready_w[k]), 32'(exp_rdy));
                check($sformatf("L%0d c%0d stall", lat_of(k), t), 32'(stall_w[k]), 32'(!exp_rdy));
                check($sformatf("L%0d c%0d rsp_valid", lat_of(k), t), 32'(rsp_valid_w[k]), 32'(exp_done));
                check($sformatf("L%0d c%0d rsp_data", lat_of(k), t), rsp_data_w[k], m_rspd[k]);
                check($sformatf("L%0d c%0d rsp_rd", lat_of(k), t), 32'(rsp_rd_w[k]), 32'(m_rd[k]));
                check($sformatf("L%0d c%0d mul_in1", lat_of(k), t), mul_in1_w[k], m_in1[k]);
                check($sformatf("L%0d c%0d mul_in2", lat_of(k), t), mul_in2_w[k], m_in2[k]);
                check($sformatf("L%0d c%0d mul_op", lat_of(k), t), 32'(mul_op_w[k]), 32'(m_op[k]));

                // Advance the model across the coming rising edge.
                if (rst) begin
                    m_busy[k] = 1'b0; t_v[k] = 1'b0;
                    m_in1[k] = '0; m_in2[k] = '0; m_op[k] = '0; m_rd[k] = '0; m_rspd[k] = '0;
                end else if (flush) begin
                    m_busy[k] = 1'b0; t_v[k] = 1'b0;
                end else begin
                    if (exp_done && rsp_ready) begin
                        m_busy[k] = 1'b0;
                        $display("txn L%0d rd=%0d data=%h latency=%0d cyc=%0d",
                                 lat_of(k), m_rd[k], m_rspd[k], m_done[k] - m_acc[k], t);
                    end
                    if (req_valid && exp_rdy) begin
                        hit = REUSE && t_v[k] && (t_op[k] == req_op) &&
                              (t_a[k] == req_rs1) && (t_b[k] == req_rs2);
                        m_in1[k]  = req_rs1;
                        m_in2[k]  = req_rs2;
                        m_op[k]   = req_op;
                        m_rd[k]   = req_rd;
                        m_data[k] = mul_ref(req_op, req_rs1, req_rs2);
                        m_busy[k] = 1'b1;
                        m_acc[k]  = t;
                        m_done[k] = hit ? t + 1 : t + 1 + lat_of(k);
                        if (!hit) begin
                            // Only an op that completes becomes the tag; any
                            // flush/rst before that clears t_v anyway.
                            t_v[k] = 1'b1; t_op[k] = req_op; t_a[k] = req_rs1; t_b[k] = req_rs2;
                        end
                    end
                end
                if (m_busy[k] && (m_done[k] == t + 1)) begin
                    m_rspd[k] = m_data[k];
                end
            end
            t++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
